// File: rtl/bridge_ser_shift_pkg.sv
// Shared definitions for the bridge serial shift engine: state encoding and
// the default bridge word width.
package bridge_ser_shift_pkg;

    localparam int BRIDGE_WIDTH = 16;

    localparam logic [1:0] IDLE_ENC  = 2'd0;
    localparam logic [1:0] ARM_ENC   = 2'd1;
    localparam logic [1:0] SHIFT_ENC = 2'd2;
    localparam logic [1:0] DONE_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE_ENC,
        ST_ARM   = ARM_ENC,
        ST_SHIFT = SHIFT_ENC,
        ST_DONE  = DONE_ENC
    } state_t;

endpackage

// File: rtl/bridge_ser_shift_if.sv
// Parallel handshake plus serial pins of the bridge shift engine.
// Handshake: a word transfers on a clk_in edge where in_valid && in_ready;
// the sender holds in_valid/in_data stable until then, ready never waits on valid.
interface bridge_ser_shift_if
    import bridge_ser_shift_pkg::*;
#(
    parameter int WIDTH = BRIDGE_WIDTH
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             sdi;
    logic             sdo;
    logic             cs_n;
    logic [WIDTH-1:0] rx_data;
    logic             done;
    logic             busy;

    modport master (
        output in_valid, in_data, sdi,
        input  in_ready, sdo, cs_n, rx_data, done, busy
    );

    modport slave (
        input  in_valid, in_data, sdi,
        output in_ready, sdo, cs_n, rx_data, done, busy
    );
endinterface

// File: rtl/sclk_edge_det.sv
// Level-sampled edge detector for the divided serial clock; sclk is already
// registered in clk_in, so a single delay stage is enough.
module sclk_edge_det (
    input  logic clk_in,
    input  logic RST_N,
    input  logic sclk,
    output logic rise,
    output logic fall
);
    logic sclk_d;

    // Resetting to 0 guarantees no spurious fall right after reset.
    always_ff @(posedge clk_in or negedge RST_N) begin
        if (!RST_N) begin
            sclk_d <= 1'b0;
        end else begin
            sclk_d <= sclk;
        end
    end

    assign fall = sclk_d & ~sclk;
    assign rise = ~sclk_d & sclk;
endmodule

// File: rtl/bridge_ser_shift.sv
// Bridge serial shift engine: MSB-first full-duplex word shifter framed by
// cs_n, launching sdo on sclk falls and capturing sdi on sclk rises.
module bridge_ser_shift
    import bridge_ser_shift_pkg::*;
#(
    parameter int WIDTH = BRIDGE_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic                     clk_in,
    input  logic                     RST_N,
    input  logic                     sclk,
    bridge_ser_shift_if.slave        bus,
    output state_t                   dbg_state
);
    // One extra bit so the counter can hold WIDTH itself when 2^CNT_W == WIDTH.
    localparam int CW = CNT_W + 1;

    state_t           state;
    logic [WIDTH-1:0] tx_sr;
    logic [WIDTH-1:0] rx_sr;
    logic [CW-1:0]    bit_cnt;
    logic             sdo_q;
    logic             cs_n_q;
    logic [WIDTH-1:0] rx_data_q;
    logic             done_q;
    logic             busy_q;
    logic             in_ready_q;
    logic             rise;
    logic             fall;

    sclk_edge_det u_edge (
        .clk_in (clk_in),
        .RST_N  (RST_N),
        .sclk   (sclk),
        .rise   (rise),
        .fall   (fall)
    );

    always_ff @(posedge clk_in or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            tx_sr      <= '0;
            rx_sr      <= '0;
            bit_cnt    <= '0;
            sdo_q      <= 1'b0;
            cs_n_q     <= 1'b1;
            rx_data_q  <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        tx_sr      <= bus.in_data;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    // Align the frame start to an sclk fall so the first bit
                    // gets a full low half-period before the first rise.
                    if (fall) begin
                        cs_n_q  <= 1'b0;
                        sdo_q   <= tx_sr[WIDTH-1];
                        tx_sr   <= tx_sr << 1;
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (rise) begin
                        rx_sr   <= {rx_sr[WIDTH-2:0], bus.sdi};
                        bit_cnt <= bit_cnt + 1'b1;
                    end else if (fall) begin
                        if (bit_cnt == CW'(WIDTH)) begin
                            cs_n_q    <= 1'b1;
                            sdo_q     <= 1'b0;
                            rx_data_q <= rx_sr;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            state     <= ST_DONE;
                        end else begin
                            sdo_q <= tx_sr[WIDTH-1];
                            tx_sr <= tx_sr << 1;
                        end
                    end
                end
                ST_DONE: begin
                    in_ready_q <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.sdo      = sdo_q;
    assign bus.cs_n     = cs_n_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
    assign bus.in_ready = in_ready_q;
    assign dbg_state    = state;
endmodule

// File: tb/tb_bridge_ser_shift.sv
// Self-checking bench for bridge_ser_shift: a frame-level protocol model
// watches sclk, sdo and sdi like a downstream device and checks every cycle.
module tb_bridge_ser_shift;
  import bridge_ser_shift_pkg::*;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic   clk_in = 1'b0;
  logic   RST_N  = 1'b0;
  logic   sclk   = 1'b0;
  state_t dbg_state;

  always #5 clk_in = ~clk_in;

  bridge_ser_shift_if #(.WIDTH(W)) bus ();

  bridge_ser_shift #(.WIDTH(W), .CNT_W(5)) dut (
    .clk_in    (clk_in),
    .RST_N     (RST_N),
    .sclk      (sclk),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- sclk / sdi stimulus ----------------
  logic sclk_run  = 1'b0;
  logic hold_high = 1'b0;
  logic sdi_loop  = 1'b1;
  logic sdi_one   = 1'b0;
  logic sdi_drv   = 1'b0;
  int   half      = 2;
  int   ph        = 0;

  assign bus.sdi = sdi_loop ? bus.sdo : sdi_drv;

  // sclk behaves like a registered divider output; the remote device
  // updates its sdi on sclk falls.
  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      if (sclk_run && !(hold_high && sclk)) begin
        ph++;
        if (ph >= half) begin
          ph   = 0;
          sclk = ~sclk;
          if (!sclk) sdi_drv = sdi_one ? 1'b1 : 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [W-1:0] exp_q[$];
  logic         got_tx[$];
  logic         got_rx[$];
  logic         s_last = 1'b0, sdo_last = 1'b0, cs_last = 1'b1, done_last = 1'b0;
  logic [W-1:0] tx_w, rx_w, last_tx_bits;
  int           cyc = 0, done_cnt = 0, acc_cnt = 0;
  int           last_done_cyc = -10, last_acc_cyc = -10;

  always @(negedge clk_in) begin
    cyc++;
    if (!RST_N) begin
      exp_q.delete();
      got_tx.delete();
      got_rx.delete();
    end else begin
      if (bus.cs_n) check("idle_sdo_low", 32'(bus.sdo), 0);
      else          check("busy_in_frame", 32'(bus.busy), 1);
      check("ready_busy_excl", 32'(bus.in_ready & bus.busy), 0);
      if (!bus.cs_n && !cs_last && (bus.sdo !== sdo_last))
        check("sdo_moves_sclk_low", 32'(sclk), 0);
      if (sclk && !s_last && !bus.cs_n) begin
        got_tx.push_back(bus.sdo);
        got_rx.push_back(bus.sdi);
      end
      if (bus.done) begin
        done_cnt++;
        last_done_cyc = cyc;
        check("done_single", 32'(done_last), 0);
        check("done_expected", 32'(exp_q.size() > 0), 1);
        check("frame_bits", 32'(got_tx.size()), W);
        tx_w = '0;
        rx_w = '0;
        for (int i = 0; i < got_tx.size(); i++) begin
          tx_w = {tx_w[W-2:0], got_tx[i]};
          rx_w = {rx_w[W-2:0], got_rx[i]};
        end
        last_tx_bits = tx_w;
        if (exp_q.size() > 0) check("tx_word", 32'(tx_w), 32'(exp_q.pop_front()));
        check("rx_word", 32'(bus.rx_data), 32'(rx_w));
        check("done_cs_n", 32'(bus.cs_n), 1);
        check("done_ready", 32'(bus.in_ready), 0);
        check("done_busy", 32'(bus.busy), 0);
        got_tx.delete();
        got_rx.delete();
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(bus.in_data);
        acc_cnt++;
        last_acc_cyc = cyc;
      end
    end
    s_last    = sclk;
    sdo_last  = bus.sdo;
    cs_last   = bus.cs_n;
    done_last = bus.done;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_acc(input int target);
    int n = 0;
    while (acc_cnt < target && n < 2000) begin
      @(negedge clk_in);
      #1;
      n++;
    end
    if (acc_cnt < target) check("timeout_accept", 0, 1);
  endtask

  task automatic send(input logic [W-1:0] word);
    int start;
    @(posedge clk_in);
    #1;
    start        = acc_cnt;
    bus.in_valid = 1'b1;
    bus.in_data  = word;
    wait_acc(start + 1);
    @(posedge clk_in);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = W'($urandom);
  endtask

  task automatic wait_done();
    int start = done_cnt;
    int n     = 0;
    while (done_cnt == start && n < 3000) begin
      @(negedge clk_in);
      #1;
      n++;
    end
    if (done_cnt == start) check("timeout_done", 0, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d;
    int n;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    RST_N = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_sdo", 32'(bus.sdo), 0);
    check("rst_cs_n", 32'(bus.cs_n), 1);
    check("rst_rx_data", 32'(bus.rx_data), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    RST_N = 1'b1;

    // Idle with sclk running: nothing may happen.
    sclk_run = 1'b1;
    half     = 2;
    repeat (40) begin
      @(negedge clk_in);
      #1;
      check("t1_cs_n", 32'(bus.cs_n), 1);
      check("t1_in_ready", 32'(bus.in_ready), 1);
    end
    check("t1_no_done", 32'(done_cnt), 0);

    // Loopback of a known word.
    sdi_loop = 1'b1;
    send(16'hA5C3);
    wait_done();
    check("t2_rx_data", 32'(bus.rx_data), 32'h0000_A5C3);
    check("t2_sdo_bits", 32'(last_tx_bits), 32'b1010010111000011);

    // sdi tied high while sending zeros.
    sdi_loop = 1'b0;
    sdi_one  = 1'b1;
    sdi_drv  = 1'b1;
    send(16'h0000);
    wait_done();
    check("t3_rx_data", 32'(bus.rx_data), 32'h0000_FFFF);
    check("t3_sdo_bits", 32'(last_tx_bits), 32'h0);

    // Held in_valid with a new word presented while busy.
    sdi_loop = 1'b1;
    sdi_one  = 1'b0;
    @(posedge clk_in);
    #1;
    d            = acc_cnt;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h1234;
    wait_acc(d + 1);
    @(posedge clk_in);
    #1;
    bus.in_data = 16'hFFFF;
    wait_done();
    check("t4_rx_first", 32'(bus.rx_data), 32'h0000_1234);
    check("t4_tx_first", 32'(last_tx_bits), 32'h0000_1234);
    wait_acc(d + 2);
    check("t4_accept_after_done", 32'(last_acc_cyc - last_done_cyc), 1);
    @(posedge clk_in);
    #1;
    bus.in_valid = 1'b0;
    wait_done();
    check("t4_rx_second", 32'(bus.rx_data), 32'h0000_FFFF);

    // Reset in the middle of a frame.
    d = done_cnt;
    @(posedge clk_in);
    #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hFFFF;
    n = acc_cnt;
    wait_acc(n + 1);
    @(posedge clk_in);
    #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (got_tx.size() < 7 && n < 2000) begin
      @(negedge clk_in);
      #1;
      n++;
    end
    check("t5_reached_7_bits", 32'(got_tx.size() >= 7), 1);
    RST_N = 1'b0;
    #1;
    check("t5_async_cs_n", 32'(bus.cs_n), 1);
    check("t5_async_sdo", 32'(bus.sdo), 0);
    check("t5_async_busy", 32'(bus.busy), 0);
    check("t5_async_ready", 32'(bus.in_ready), 1);
    repeat (3) @(posedge clk_in);
    #1;
    RST_N = 1'b1;
    repeat (10) begin
      @(negedge clk_in);
      #1;
      check("t5_rx_held_zero", 32'(bus.rx_data), 0);
    end
    check("t5_no_done", 32'(done_cnt - d), 0);
    send(16'h8001);
    wait_done();
    check("t5_rx_after", 32'(bus.rx_data), 32'h0000_8001);

    // sclk stalled high after acceptance.
    hold_high = 1'b1;
    n = 0;
    while (!sclk && n < 100) begin
      @(negedge clk_in);
      #1;
      n++;
    end
    send(16'h5A0F);
    repeat (100) begin
      @(negedge clk_in);
      #1;
      check("t6_busy", 32'(bus.busy), 1);
      check("t6_cs_n", 32'(bus.cs_n), 1);
      check("t6_state", 32'(dbg_state), 32'(ST_ARM));
    end
    hold_high = 1'b0;
    wait_done();
    check("t6_rx", 32'(bus.rx_data), 32'h0000_5A0F);

    // Randomized frames with random sdi and sclk rates.
    sdi_loop = 1'b0;
    sdi_one  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      half = $urandom_range(2, 5);
      send(W'($urandom));
      wait_done();
      repeat ($urandom_range(0, 5)) @(posedge clk_in);
    end
    check("rand_all_done", 32'(exp_q.size()), 0);

    repeat (5) @(posedge clk_in);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end
endmodule
